// File: rtl/coin_credit_module_if.sv
// Coin, selection and dispenser signals of the coin credit block, bundled for port use.
// The master side drives sensors and requests; the slave side is the credit logic.
interface coin_credit_module_if;
    logic       coin_100;
    logic       coin_500;
    logic [2:0] coffee_type;
    logic       request;
    logic       cancel;
    logic       busy;
    logic [3:0] total_coins;
    logic [3:0] change;
    logic       enable;
    logic       refund;
    logic       reject;
    logic [1:0] state;

    modport master (
        output coin_100, coin_500, coffee_type, request, cancel, busy,
        input  total_coins, change, enable, refund, reject, state
    );

    modport slave (
        input  coin_100, coin_500, coffee_type, request, cancel, busy,
        output total_coins, change, enable, refund, reject, state
    );
endinterface

// File: rtl/coin_credit_module.sv
// Coin credit accumulator with per-sensor debouncing, price check, refund and vend handshake.
// All outputs come straight from registers.

module coin_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic coin_event
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] stable_cnt;
    logic             level_q;
    logic             level_prev_q;
    logic             hold_off_q;

    // hold_off stays set after reset until the sensor is seen empty, so a coin
    // sitting in the slot during reset is never credited.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable_cnt   <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            hold_off_q   <= 1'b1;
        end else begin
            level_prev_q <= level_q;
            if (!raw && !level_q) begin
                hold_off_q <= 1'b0;
            end
            if (raw != level_q) begin
                if (stable_cnt == LAST_COUNT) begin
                    level_q    <= raw;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    assign coin_event = level_q & ~level_prev_q & ~hold_off_q;
endmodule

module coin_credit_module #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_CREDIT      = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    coin_credit_module_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        VEND = 2'b01,
        WAIT = 2'b10
    } state_t;

    localparam logic [4:0] MAX_SUM = 5'(MAX_CREDIT);

    state_t     state_q, state_d;
    logic [3:0] total_q, total_d;
    logic [3:0] change_q, change_d;
    logic       enable_q, enable_d;
    logic       refund_q, refund_d;
    logic       reject_q, reject_d;
    logic       request_prev_q;

    logic       event_100;
    logic       event_500;
    logic       any_coin;
    logic [3:0] coin_sum;
    logic [4:0] credit_sum;
    logic [3:0] price;
    logic       type_valid;
    logic       request_rise;

    coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_100 (
        .clock      (clock),
        .reset      (reset),
        .raw        (bus.coin_100),
        .coin_event (event_100)
    );

    coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_500 (
        .clock      (clock),
        .reset      (reset),
        .raw        (bus.coin_500),
        .coin_event (event_500)
    );

    always_comb begin
        price      = 4'd0;
        type_valid = 1'b1;
        case (bus.coffee_type)
            3'b000:  price = 4'd3;
            3'b001:  price = 4'd4;
            3'b010:  price = 4'd5;
            3'b011:  price = 4'd6;
            3'b100:  price = 4'd8;
            default: type_valid = 1'b0;
        endcase
    end

    // The sum is checked one bit wider so that 10 + 6 cannot wrap into a false fit.
    assign any_coin     = event_100 | event_500;
    assign coin_sum     = (event_100 ? 4'd1 : 4'd0) + (event_500 ? 4'd5 : 4'd0);
    assign credit_sum   = {1'b0, total_q} + {1'b0, coin_sum};
    assign request_rise = bus.request & ~request_prev_q;

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        change_d = change_q;
        enable_d = 1'b0;
        refund_d = 1'b0;
        reject_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cancel && (total_q != 4'd0)) begin
                    change_d = total_q;
                    total_d  = 4'd0;
                    refund_d = 1'b1;
                    reject_d = any_coin;
                end else if (request_rise) begin
                    if (type_valid && (total_q >= price)) begin
                        change_d = total_q - price;
                        total_d  = 4'd0;
                        state_d  = VEND;
                        enable_d = 1'b1;
                        reject_d = any_coin;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (any_coin) begin
                    if (credit_sum <= MAX_SUM) begin
                        total_d  = credit_sum[3:0];
                        change_d = 4'd0;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            VEND: begin
                reject_d = any_coin;
                if (bus.busy) begin
                    state_d = WAIT;
                end else begin
                    enable_d = 1'b1;
                end
            end
            WAIT: begin
                reject_d = any_coin;
                if (!bus.busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            total_q        <= 4'd0;
            change_q       <= 4'd0;
            enable_q       <= 1'b0;
            refund_q       <= 1'b0;
            reject_q       <= 1'b0;
            request_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            total_q        <= total_d;
            change_q       <= change_d;
            enable_q       <= enable_d;
            refund_q       <= refund_d;
            reject_q       <= reject_d;
            request_prev_q <= bus.request;
        end
    end

    assign bus.total_coins = total_q;
    assign bus.change      = change_q;
    assign bus.enable      = enable_q;
    assign bus.refund      = refund_q;
    assign bus.reject      = reject_q;
    assign bus.state       = state_q;
endmodule
